// File: rtl/apb_mem_completer_pkg.sv
// Shared types and helpers for the APB memory completer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package apb_mem_completer_pkg;

    // Bus phase of the current cycle. SETUP is never held in a register. It is
    // recognised directly from psel & !penable so that ACCESS follows on the next edge.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic {
        RESP_OKAY   = 1'b0,
        RESP_SLVERR = 1'b1
    } resp_e;

    // Odd parity bit for one byte: data bits plus this bit have odd weight.
    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/apb_mem_completer_parity.sv
// Per-byte odd-parity generator; callers compare against the received check bits.
// Latency: combinational.
// Backpressure: none.
module apb_mem_completer_parity
    import apb_mem_completer_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic [BYTES*8-1:0] dat,
    output logic [BYTES-1:0]   par
);

    // One odd-parity bit per byte lane.
    always_comb begin
        par = '0;
        for (int i = 0; i < BYTES; i++) begin
            par[i] = odd_par(dat[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/apb_mem_completer.sv
// APB4/APB5 completer: byte-strobed word memory with decode, error and parity.
// Latency: pready rises in access cycle WAIT_STATES+1; a transfer takes WAIT_STATES+2 cycles.
// Backpressure: pready is held low for WAIT_STATES access cycles; a protocol violation aborts.
module apb_mem_completer
    import apb_mem_completer_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter int                    PRIV_ONLY   = 0,
    parameter int                    CHK_EN      = 0
) (
    input  logic                      pclk,
    input  logic                      prst_n,
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [2:0]                pprot,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [STRB_WIDTH-1:0]     pstrb,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    input  logic [ADDR_WIDTH/8-1:0]   paddrchk,
    input  logic [STRB_WIDTH-1:0]     pwdatachk,
    output logic [STRB_WIDTH-1:0]     prdatachk,
    output logic                      preadychk,
    output logic                      pslverrchk,
    output logic                      parity_err
);

    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int LANE_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam longint unsigned MEM_BYTES = 64'(MEM_DEPTH) * 64'(STRB_WIDTH);

    logic [1:0]            st_q;
    logic [1:0]            phase;
    logic [3:0]            wait_q;
    logic                  wr_q;
    resp_e                 resp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [IDX_W-1:0]      idx_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx_d;
    logic                  below_base;
    logic                  beyond_end;
    logic                  misaligned;
    logic                  priv_fail;
    logic                  chk_fail;
    logic                  dec_err;
    logic                  violation;
    logic                  ready_int;
    logic                  rd_hit;
    logic                  commit;

    logic [ADDR_BYTES-1:0] addr_par;
    logic [STRB_WIDTH-1:0] wdata_par;

    // pprot[2:1] carry no meaning for this target.
    logic                  unused_prot;
    assign unused_prot = ^pprot[2:1];

    apb_mem_completer_parity #(.BYTES(ADDR_BYTES)) u_addr_par (
        .dat (paddr),
        .par (addr_par)
    );

    apb_mem_completer_parity #(.BYTES(STRB_WIDTH)) u_wdata_par (
        .dat (pwdata),
        .par (wdata_par)
    );

    apb_mem_completer_parity #(.BYTES(STRB_WIDTH)) u_rdata_par (
        .dat (prdata),
        .par (prdatachk)
    );

    // Address decode and input-parity check, evaluated against the live bus in SETUP.
    // Write-data parity only matters when there is write data to protect.
    always_comb begin
        offset     = paddr - BASE_ADDR;
        idx_d      = IDX_W'(offset >> LANE_LSB);
        below_base = (paddr < BASE_ADDR);
        beyond_end = (64'(offset) >= MEM_BYTES);
        misaligned = ((paddr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0);
        priv_fail  = (PRIV_ONLY != 0) && !pprot[0];
        chk_fail   = (CHK_EN != 0) &&
                     ((addr_par != paddrchk) || (pwrite && (wdata_par != pwdatachk)));
        dec_err    = below_base || beyond_end || misaligned || priv_fail || chk_fail;
    end

    // Current bus phase: a registered ACCESS takes priority, otherwise SETUP is seen on the bus.
    always_comb begin
        phase = ST_IDLE;
        if (st_q == ST_ACCESS) begin
            phase = ST_ACCESS;
        end else if (psel && !penable) begin
            phase = ST_SETUP;
        end
    end

    // Response path: the requester must hold psel/penable/paddr/pwrite through ACCESS.
    // If it does not, the transfer is dropped silently, with no pready and no write.
    always_comb begin
        violation = (st_q == ST_ACCESS) &&
                    (!psel || !penable || (paddr != addr_q) || (pwrite != wr_q));
        ready_int = (st_q == ST_ACCESS) && (wait_q == 4'd0) && !violation;
        rd_hit    = ready_int && !wr_q && (resp_q == RESP_OKAY);
        commit    = ready_int &&  wr_q && (resp_q == RESP_OKAY);
    end

    assign pready     = ready_int;
    assign pslverr    = ready_int && (resp_q == RESP_SLVERR);
    assign prdata     = rd_hit ? mem[idx_q] : '0;
    assign preadychk  = odd_par({7'b0, ready_int});
    assign pslverrchk = odd_par({7'b0, pslverr});
    assign parity_err = (phase == ST_SETUP) && chk_fail;

    // Phase tracking, wait counter and SETUP-time capture of the decoded transfer.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            st_q   <= ST_IDLE;
            wait_q <= 4'd0;
            wr_q   <= 1'b0;
            resp_q <= RESP_OKAY;
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            case (phase)
                ST_SETUP: begin
                    st_q   <= ST_ACCESS;
                    wait_q <= 4'(WAIT_STATES);
                    wr_q   <= pwrite;
                    addr_q <= paddr;
                    idx_q  <= idx_d;
                    resp_q <= dec_err ? RESP_SLVERR : RESP_OKAY;
                end
                ST_ACCESS: begin
                    if (violation || ready_int) begin
                        st_q <= ST_IDLE;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                default: begin
                    st_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array, deliberately not reset. Only the strobed lanes change on a good write.
    always_ff @(posedge pclk) begin
        if (commit) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (pstrb[i]) begin
                    mem[idx_q][i*8 +: 8] <= pwdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Randomised scoreboard bench for apb_mem_completer (WAIT_STATES=2, PRIV_ONLY=1, CHK_EN=1).
// Latency: each completion is checked for WAIT_STATES+1 access cycles.
// Backpressure: the driver waits on pready with a bounded cycle budget.
module tb_apb_mem_completer;

    localparam int          DEPTH = 64;
    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic [31:0] paddr = '0;
    logic [2:0]  pprot = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [3:0]  paddrchk = '0;
    logic [3:0]  pwdatachk = '0;
    logic [3:0]  prdatachk;
    logic        preadychk;
    logic        pslverrchk;
    logic        parity_err;

    always #5 pclk = ~pclk;

    apb_mem_completer #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STRB_WIDTH  (4),
        .MEM_DEPTH   (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS),
        .PRIV_ONLY   (1),
        .CHK_EN      (1)
    ) dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
        .paddr      (paddr),
        .pprot      (pprot),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .paddrchk   (paddrchk),
        .pwdatachk  (pwdatachk),
        .prdatachk  (prdatachk),
        .preadychk  (preadychk),
        .pslverrchk (pslverrchk),
        .parity_err (parity_err)
    );

    typedef struct {
        bit          wr;
        bit          err;
        bit          perr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Odd parity per byte from the population count.
    function automatic logic [3:0] par4(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = (($countones(d[i*8 +: 8]) % 2) == 0);
        end
        return p;
    endfunction

    // Transfer is rejected if the address is outside the window, not word-aligned, unprivileged, or has bad parity.
    function automatic bit model_err(input logic [31:0] a, input logic [2:0] prot, input bit bad_par);
        longint off;
        off = longint'({32'b0, a}) - longint'({32'b0, BASE});
        return (off < 0) || (off >= DEPTH * 4) || ((a % 4) != 0) || (prot[0] == 1'b0) || bad_par;
    endfunction

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] prot, input bit bad_apar, input bit bad_wpar);
        exp_t e;
        int   idx;
        int   waited;
        e.wr    = wr;
        e.perr  = bad_apar || (wr && bad_wpar);
        e.err   = model_err(a, prot, e.perr);
        e.rdata = '0;
        if (!e.err) begin
            idx = int'((a - BASE) / 4);
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
                end
            end else begin
                e.rdata = model[idx];
            end
        end
        expq.push_back(e);
        @(posedge pclk); #1;
        psel      = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = a;
        pwdata    = d;
        pstrb     = s;
        pprot     = prot;
        paddrchk  = par4(a) ^ {3'b0, bad_apar};
        pwdatachk = par4(d) ^ {3'b0, bad_wpar};
        @(posedge pclk); #1;
        penable = 1'b1;
        waited = 0;
        @(negedge pclk);
        while (pready !== 1'b1 && waited < 40) begin
            @(negedge pclk);
            waited++;
        end
        if (pready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL pready_timeout addr=%h actual=0 expected=1", a);
            e = expq.pop_back();
        end
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pready"},     32'(pready),     32'd0);
        check({tag, "_prdata"},     prdata,          32'd0);
        check({tag, "_pslverr"},    32'(pslverr),    32'd0);
        check({tag, "_prdatachk"},  32'(prdatachk),  32'hF);
        check({tag, "_preadychk"},  32'(preadychk),  32'd1);
        check({tag, "_pslverrchk"}, 32'(pslverrchk), 32'd1);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    endtask

    // Monitor: counts access cycles, checks parity_err in SETUP and every completion against the queue.
    initial begin
        int   acc;
        exp_t e;
        acc = 0;
        forever begin
            @(negedge pclk);
            if (prst_n) begin
                if (psel && !penable) begin
                    acc = 0;
                    check("parity_err_setup", 32'(parity_err), (expq.size() > 0) ? 32'(expq[0].perr) : 32'd0);
                end else if (psel && penable) begin
                    acc++;
                    if (pready) begin
                        if (expq.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_completion addr=%h actual=1 expected=0", paddr);
                        end else begin
                            e = expq.pop_front();
                            check("latency", 32'(acc), 32'(WS + 1));
                            check("pslverr", 32'(pslverr), 32'(e.err));
                            check("pslverrchk", 32'(pslverrchk), 32'(!e.err));
                            check("preadychk", 32'(preadychk), 32'd0);
                            if (!e.wr) begin
                                check("prdata", prdata, e.rdata);
                                check("prdatachk", 32'(prdatachk), 32'(par4(e.rdata)));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  prot;
        exp_t        e;
        int          r;
        int          waited;
        bit          wr;

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs("reset");
        @(posedge pclk); #1;
        prst_n = 1'b1;

        // Fill every word so later reads have known contents.
        for (int i = 0; i < DEPTH; i++) begin
            xfer(1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        end

        // Directed: plain write/read, strobed merge, boundaries, parity, privilege, empty strobe.
        xfer(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b0, BASE + 32'h10, $urandom, 4'h0, 3'b001, 1'b0, 1'b0);
        xfer(1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b1, BASE + 32'h14, 32'h1122_3344, 4'b0101, 3'b001, 1'b0, 1'b0);
        xfer(1'b0, BASE + 32'h14, $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b1, BASE + 32'(DEPTH * 4), 32'h1234_5678, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b1, BASE + 32'h12, 32'h1234_5678, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b1, BASE - 32'd4, 32'h1234_5678, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b0, BASE + 32'(DEPTH * 4 - 4), $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b0, BASE + 32'h10, $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b1, BASE + 32'h18, 32'hCAFE_F00D, 4'hF, 3'b001, 1'b0, 1'b1);
        xfer(1'b0, BASE + 32'h18, $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b0, BASE + 32'h1C, $urandom, 4'hF, 3'b001, 1'b1, 1'b0);
        xfer(1'b1, BASE + 32'h18, 32'h0000_0055, 4'hF, 3'b000, 1'b0, 1'b0);
        xfer(1'b1, BASE + 32'h18, 32'h7777_7777, 4'h0, 3'b001, 1'b0, 1'b0);
        xfer(1'b0, BASE + 32'h18, $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        idle();

        // Randomised traffic, mostly back-to-back.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (r < 85) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
            else if (r < 90) a = BASE - 32'($urandom_range(1, 16) * 4);
            else             a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
            wr   = 1'($urandom_range(0, 1));
            prot = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) != 0)};
            xfer(wr, a, $urandom, 4'($urandom_range(0, 15)), prot,
                 $urandom_range(0, 19) == 0, wr && ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // Protocol violation: paddr changes in the cycle pready would rise; nothing is written.
        a = BASE + 32'h20;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = 32'hA5A5_5A5A;
        pstrb = 4'hF; pprot = 3'b001; paddrchk = par4(a); pwdatachk = par4(pwdata);
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (WS) @(posedge pclk);
        #1;
        paddr = a + 32'd4;
        paddrchk = par4(paddr);
        @(negedge pclk);
        check("abort_pready", 32'(pready), 32'd0);
        idle();
        xfer(1'b0, a, $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        xfer(1'b0, a + 32'd4, $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        idle();

        // Reset while a write is presenting pready: outputs clear at once and the write is lost.
        a = BASE + 32'h30;
        e.wr = 1'b1; e.err = 1'b0; e.perr = 1'b0; e.rdata = '0;
        expq.push_back(e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = 32'h0BAD_F00D;
        pstrb = 4'hF; pprot = 3'b001; paddrchk = par4(a); pwdatachk = par4(pwdata);
        @(posedge pclk); #1;
        penable = 1'b1;
        waited = 0;
        @(negedge pclk);
        while (pready !== 1'b1 && waited < 40) begin
            @(negedge pclk);
            waited++;
        end
        check("reset_test_pready_seen", 32'(pready), 32'd1);
        #1;
        prst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        psel = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        prst_n = 1'b1;
        xfer(1'b0, a, $urandom, 4'hF, 3'b001, 1'b0, 1'b0);
        idle();

        repeat (5) @(posedge pclk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
